ks_loader32: RTL

Receiver for the key-schedule output bundle (C state words, X words, done level). Captures C and X on the rising edge of the key schedule's done and optionally re-verifies that all 32-bit X words are pairwise distinct. It then streams the bundle as 32-bit words over a valid/ready handshake to the permutation-core state loader. The block sits between the key schedule and the GASCON core input port.

---
 rtl/ks_pkg.sv | 20 ++
 rtl/ks_word_mux.sv | 24 ++
 rtl/ks_loader32.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared types and helpers for the key-schedule bundle loader and its
// wide-register readers.
package ks_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_STREAM,
        ST_DONE,
        ST_ERROR
    } ks_ld_state_t;

    // Number of 32-bit words in a register of the given bit width.
    function automatic int nwords(input int width);
        return width / WORD_W;
    endfunction

endpackage

// File: rtl/ks_word_mux.sv
// Combinational NW-to-1 selector of 32-bit words from a flat wide register.
// Word n occupies bits [n*32 +: 32]; a select beyond NW-1 yields zero.
module ks_word_mux
    import ks_pkg::*;
#(
    parameter int NW = 6,
    parameter int KW = 3
) (
    input  logic [NW*WORD_W-1:0] words,
    input  logic [KW-1:0]        sel,
    output logic [WORD_W-1:0]    word
);

    // Pick the word whose index matches sel.
    always_comb begin
        word = '0;
        for (int n = 0; n < NW; n++) begin
            if (sel == KW'(n)) begin
                word = words[n*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/ks_loader32.sv
// Key-schedule bundle loader: captures C/X on the rising edge of ks_done,
// optionally checks that all X words are pairwise distinct, then streams
// the C words followed by the X words over a valid/ready word interface.
// Build option: define KS_LOADER_XCHECK_EN to compile in the duplicate-X
// check (CHECK and ERROR states and the pair counters).
module ks_loader32
    import ks_pkg::*;
#(
    parameter int CWIDTH = 128,
    parameter int XWIDTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ks_done,
    input  logic [CWIDTH-1:0] ks_cout,
    input  logic [XWIDTH-1:0] ks_xout,
    output logic [31:0]       word_data,
    output logic              word_valid,
    output logic              word_last,
    input  logic              word_ready,
    output logic              busy,
    output logic              err,
    output logic              loaded
);

    localparam int CW = nwords(CWIDTH);
    localparam int XW = nwords(XWIDTH);
    localparam int NW = CW + XW;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

    ks_ld_state_t      state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CWIDTH-1:0] c_q, c_d;
    logic [XWIDTH-1:0] x_q, x_d;
    logic              ks_done_q, ks_done_d;
    logic              armed_q, armed_d;
    logic              start;
    logic [31:0]       mux_word;

    // A ks_done that is already high when reset releases is not a rise:
    // the edge detector only arms once ks_done has been seen low.
    assign start = ks_done & ~ks_done_q & armed_q;

    ks_word_mux #(.NW(NW), .KW(KW)) u_out_mux (
        .words (({x_q, c_q})),
        .sel   (k_q),
        .word  (mux_word)
    );

`ifdef KS_LOADER_XCHECK_EN
    localparam int IW = (XW > 1) ? $clog2(XW) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(XW - 2);
    localparam logic [IW-1:0] J_LAST = IW'(XW - 1);

    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [31:0]   x_i, x_j;

    ks_word_mux #(.NW(XW), .KW(IW)) u_xi_mux (
        .words (x_q),
        .sel   (i_q),
        .word  (x_i)
    );

    ks_word_mux #(.NW(XW), .KW(IW)) u_xj_mux (
        .words (x_q),
        .sel   (j_q),
        .word  (x_j)
    );
`endif

    // Next-state logic: capture, pair check, word stepping and hand-back.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        k_d       = k_q;
        c_d       = c_q;
        x_d       = x_q;
        ks_done_d = ks_done;
        armed_d   = armed_q | ~ks_done;
`ifdef KS_LOADER_XCHECK_EN
        i_d       = i_q;
        j_d       = j_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    c_d = ks_cout;
                    x_d = ks_xout;
                    k_d = '0;
`ifdef KS_LOADER_XCHECK_EN
                    i_d     = '0;
                    j_d     = IW'(1);
                    state_d = ST_CHECK;
`else
                    state_d = ST_STREAM;
`endif
                end
            end
`ifdef KS_LOADER_XCHECK_EN
            ST_CHECK: begin
                if (XW < 2) begin
                    state_d = ST_STREAM;
                end else if (x_i == x_j) begin
                    state_d = ST_ERROR;
                end else if (j_q == J_LAST) begin
                    if (i_q == I_LAST) begin
                        state_d = ST_STREAM;
                    end else begin
                        i_d = i_q + IW'(1);
                        j_d = i_q + IW'(2);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            ST_ERROR: begin
                if (!ks_done) state_d = ST_IDLE;
            end
`endif
            ST_STREAM: begin
                if (word_ready) begin
                    if (k_q == K_LAST) state_d = ST_DONE;
                    else               k_d     = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                if (!ks_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the captured C/X registers are cleared too, so word_data reads zero straight out of reset.
            state_q   <= ST_IDLE;
            k_q       <= '0;
            c_q       <= '0;
            x_q       <= '0;
            ks_done_q <= 1'b0;
            armed_q   <= 1'b0;
`ifdef KS_LOADER_XCHECK_EN
            i_q       <= '0;
            j_q       <= IW'(1);
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            k_q       <= k_d;
            c_q       <= c_d;
            x_q       <= x_d;
            ks_done_q <= ks_done_d;
            armed_q   <= armed_d;
`ifdef KS_LOADER_XCHECK_EN
            i_q       <= i_d;
            j_q       <= j_d;
`endif
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        word_valid = (state_q == ST_STREAM);
        word_last  = word_valid & (k_q == K_LAST);
        word_data  = word_valid ? mux_word : 32'h0;
        busy       = (state_q == ST_CHECK) | (state_q == ST_STREAM);
        loaded     = (state_q == ST_DONE);
`ifdef KS_LOADER_XCHECK_EN
        err        = (state_q == ST_ERROR);
`else
        err        = 1'b0;
`endif
    end

endmodule
